// File: rtl/drain_buffer_loader.sv
// Drain buffer loader: streams accumulator rows into the banked drain RAM,
// bank-rotated per frame, then pulses done once the write pipe has flushed.
module drain_buffer_loader #(
  parameter int LINWDTH = 9,
  parameter int ADDRLEN = 3,
  parameter int WORDLEN = 16,
  parameter int PLDEPTH = 2
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic [LINWDTH-ADDRLEN-1:0]                    cfgEOF,
  input  logic [LINWDTH-ADDRLEN-1:0]                    cfgNumIters,
  input  logic [ADDRLEN-1:0]                            cfgRot,
  input  logic                                          inValid,
  output logic                                          inReady,
  input  logic [(2**ADDRLEN)*WORDLEN-1:0]               inData,
  output logic [(2**ADDRLEN)*(LINWDTH-ADDRLEN)-1:0]     wrAddr,
  output logic [(2**ADDRLEN)-1:0]                       wrEn,
  output logic [(2**ADDRLEN)*WORDLEN-1:0]               wrData,
  output logic                                          busy,
  output logic                                          done
);

  localparam int AW = LINWDTH - ADDRLEN;
  localparam int B  = 2**ADDRLEN;
  localparam int FW = $clog2(PLDEPTH + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [AW-1:0]      r_eof;
  logic [AW-1:0]      r_niters;
  logic [ADDRLEN-1:0] r_rotstep;
  logic [AW-1:0]      r_off;
  logic [AW-1:0]      r_iter;
  logic [AW-1:0]      r_base;
  logic [ADDRLEN-1:0] r_rot;
  logic [FW-1:0]      r_fcnt;

  logic [B-1:0]         r_wrEn;
  logic [B*AW-1:0]      r_wrAddr;
  logic [B*WORDLEN-1:0] r_wrData;

  logic                 w_accept;
  logic                 w_eol;
  logic                 w_last;
  logic                 w_degen;
  logic [AW-1:0]        w_addr;
  logic [B*WORDLEN-1:0] w_rot_data;

  assign w_eol   = (r_off == r_eof - AW'(1));
  assign w_last  = w_eol && (r_iter == r_niters - AW'(1));
  assign w_degen = (cfgEOF == '0) || (cfgNumIters == '0);
  assign w_addr  = r_base + r_off;

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = w_degen ? S_FLUSH : S_LOAD;
      end
      S_LOAD: begin
        w_accept = inValid;
        if (inValid && w_last) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (r_fcnt == FW'(PLDEPTH)) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Bank k takes word (k + rot) mod B: a right rotation of the beat.
  always_comb begin
    w_rot_data = '0;
    for (int k = 0; k < B; k++) begin
      w_rot_data[k*WORDLEN +: WORDLEN] =
        inData[int'(ADDRLEN'(k) + r_rot) * WORDLEN +: WORDLEN];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_eof     <= '0;
      r_niters  <= '0;
      r_rotstep <= '0;
      r_off     <= '0;
      r_iter    <= '0;
      r_base    <= '0;
      r_rot     <= '0;
      r_fcnt    <= '0;
      r_wrEn    <= '0;
      r_wrAddr  <= '0;
      r_wrData  <= '0;
    end else begin
      r_state <= w_next;
      r_wrEn  <= {B{w_accept}};

      if (r_state == S_FLUSH) r_fcnt <= r_fcnt + FW'(1);
      else                    r_fcnt <= '0;

      if (r_state == S_IDLE && start) begin
        r_eof     <= cfgEOF;
        r_niters  <= cfgNumIters;
        r_rotstep <= cfgRot;
        r_off     <= '0;
        r_iter    <= '0;
        r_base    <= '0;
        r_rot     <= '0;
      end

      if (w_accept) begin
        r_wrAddr <= {B{w_addr}};
        r_wrData <= w_rot_data;
        if (w_eol) begin
          r_off  <= '0;
          r_iter <= r_iter + AW'(1);
          r_base <= r_base + r_eof;
          r_rot  <= r_rot + r_rotstep;
        end else begin
          r_off <= r_off + AW'(1);
        end
      end
    end
  end

  assign inReady = (r_state == S_LOAD);
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign wrEn    = r_wrEn;
  assign wrAddr  = r_wrAddr;
  assign wrData  = r_wrData;

endmodule

// File: tb/tb_drain_buffer_loader.sv
// Directed bench for drain_buffer_loader: address/rotation sequences,
// backpressure, degenerate configs, wrap, reset abort, ignored start.
module tb_drain_buffer_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [5:0]   cfgEOF;
  logic [5:0]   cfgNumIters;
  logic [2:0]   cfgRot;
  logic         inValid;
  logic         inReady;
  logic [127:0] inData;
  logic [47:0]  wrAddr;
  logic [7:0]   wrEn;
  logic [127:0] wrData;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  drain_buffer_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .cfgEOF(cfgEOF), .cfgNumIters(cfgNumIters), .cfgRot(cfgRot),
    .inValid(inValid), .inReady(inReady), .inData(inData),
    .wrAddr(wrAddr), .wrEn(wrEn), .wrData(wrData),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mkbeat(input int n);
    logic [127:0] b;
    for (int j = 0; j < 8; j++) b[j*16 +: 16] = 16'(256 * n + j);
    return b;
  endfunction

  function automatic logic [127:0] exp_data(input int n, input int r);
    logic [127:0] e;
    for (int k = 0; k < 8; k++) e[k*16 +: 16] = 16'(256 * n + ((k + r) % 8));
    return e;
  endfunction

  function automatic logic [47:0] exp_addr(input int a);
    logic [47:0] e;
    for (int k = 0; k < 8; k++) e[k*6 +: 6] = 6'(a % 64);
    return e;
  endfunction

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int eof, input int nit, input int rot,
                         input bit gaps, input int abort_at, input int poke);
    int nb, cyc, off, it, base, rr, lat, tot;
    bit v;
    logic [127:0] last_d;
    tot = eof * nit;
    nb = 0; cyc = 0; off = 0; it = 0; base = 0; rr = 0; lat = 0;
    last_d = '0;
    start = 1'b1;
    cfgEOF = 6'(eof);
    cfgNumIters = 6'(nit);
    cfgRot = 3'(rot);
    inValid = (tot == 0);
    cyc1();
    start = 1'b0;
    chk("busy_start", busy, 1);
    if (tot == 0) begin
      for (int i = 1; i <= 12; i++) begin
        if (done) begin
          lat = i;
          break;
        end
        chk("degen_rdy", inReady, 0);
        chk("degen_wren", wrEn, 0);
        cyc1();
      end
      inValid = 1'b0;
      chk("degen_lat", lat, 4);
    end else begin
      while (nb < tot && cyc < 400) begin
        if (nb == abort_at) begin
          reset = 1'b1;
          inValid = 1'b1;
          cyc1();
          chk("rst_wren", wrEn, 0);
          chk("rst_busy", busy, 0);
          chk("rst_rdy", inReady, 0);
          chk("rst_done", done, 0);
          reset = 1'b0;
          inValid = 1'b0;
          for (int i = 0; i < 6; i++) begin
            cyc1();
            chk("rst_nodone", done, 0);
            chk("rst_nowr", wrEn, 0);
          end
          return;
        end
        v = gaps ? (cyc % 3 == 0) : 1'b1;
        chk("rdy", inReady, 1);
        if (cyc == poke) begin
          start = 1'b1;
          cfgEOF = 6'd3;
          cfgNumIters = 6'd1;
          cfgRot = 3'd5;
        end else begin
          start = 1'b0;
        end
        inValid = v;
        inData = mkbeat(nb);
        cyc1();
        chk("wren", wrEn, v ? 8'hFF : 8'h00);
        if (v) begin
          last_d = exp_data(nb, rr);
          chk("addr", wrAddr, exp_addr(base + off));
          chk("data", wrData, last_d);
          nb++;
          if (off == eof - 1) begin
            off = 0;
            it++;
            base = (base + eof) % 64;
            rr = (rr + rot) % 8;
          end else begin
            off++;
          end
        end
        cyc++;
      end
      start = 1'b0;
      inValid = 1'b1;
      chk("beats", nb, tot);
      for (int i = 1; i <= 12; i++) begin
        cyc1();
        if (done) begin
          lat = i;
          break;
        end
        chk("flush_rdy", inReady, 0);
        chk("flush_busy", busy, 1);
        if (i == 1) begin
          chk("flush_wren", wrEn, 0);
          chk("hold_data", wrData, last_d);
        end
      end
      inValid = 1'b0;
      chk("done_lat", lat, 3);
    end
    cyc1();
    chk("done_once", done, 0);
    chk("idle_busy", busy, 0);
    cyc1();
    chk("done_none", done, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    cfgEOF = '0;
    cfgNumIters = '0;
    cfgRot = '0;
    inValid = 1'b0;
    inData = '0;
    repeat (2) cyc1();
    chk("r_rdy", inReady, 0);
    chk("r_wren", wrEn, 0);
    chk("r_addr", wrAddr, 0);
    chk("r_data", wrData, 0);
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    reset = 1'b0;
    cyc1();

    do_load(5, 2, 3, 1'b0, -1, -1);
    do_load(5, 2, 3, 1'b1, -1, -1);
    do_load(5, 0, 3, 1'b0, -1, -1);
    do_load(0, 2, 3, 1'b0, -1, -1);
    do_load(40, 2, 1, 1'b0, -1, -1);
    do_load(5, 2, 3, 1'b0, 3, -1);
    do_load(5, 2, 3, 1'b0, -1, -1);
    do_load(5, 2, 3, 1'b0, -1, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
